// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, legal parameter ranges and parity helper.
// Used by the TX path and the matching RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int MIN_DIV       = 2;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  // Narrow words are zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-array synchronous FIFO with push/pop/full/empty/level.
// Push is refused when full even if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == (AW+1)'(DEPTH));
  assign empty     = (level_r == (AW+1)'(0));
  assign level     = level_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with input FIFO and runtime baud divisor.
// Optional parity bit when UART_TX_PARITY_EN is defined (adds the parity_odd port).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [DATA_BITS-1:0] rd_data_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;
  logic                 bit_end_s;
  logic                 frame_end_s;
  logic [DIV_W-1:0]     div_last_s;

  uart_state_e          state_r;
  logic [DIV_W-1:0]     div_last_r;
  logic [DIV_W-1:0]     baud_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [3:0]           bit_cnt_r;
  logic [1:0]           stop_cnt_r;
  logic                 tx_r;
`ifdef UART_TX_PARITY_EN
  logic                 par_r;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (fifo_level)
  );

  // Terminal count of the baud counter, clamped so a bit is never shorter than MIN_DIV clocks
  always_comb begin
    if (baud_div < DIV_W'(MIN_DIV)) begin
      div_last_s = DIV_W'(MIN_DIV - 1);
    end else begin
      div_last_s = baud_div - DIV_W'(1);
    end
  end

  assign bit_end_s   = (baud_cnt_r == div_last_r);
  assign frame_end_s = (state_r == ST_STOP) && bit_end_s && (stop_cnt_r == 2'(STOP_BITS - 1));
  assign pop_s       = ((state_r == ST_IDLE) || frame_end_s) && !empty_s;
  assign in_ready    = !full_s;
  assign tx          = tx_r;
  assign busy        = (state_r != ST_IDLE) || !empty_s;

  // Frame FSM: a pop starts a frame and latches word, divisor and parity sense
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      div_last_r <= '0;
      baud_cnt_r <= '0;
      shift_r    <= '0;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 2'd0;
      tx_r       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else if (pop_s) begin
      state_r    <= ST_START;
      div_last_r <= div_last_s;
      baud_cnt_r <= '0;
      shift_r    <= rd_data_s;
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 2'd0;
      tx_r       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r      <= calc_parity(DATA_BITS_MAX'(rd_data_s), parity_odd);
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            baud_cnt_r <= '0;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (!bit_end_s) begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
          end else if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
            baud_cnt_r <= '0;
`ifdef UART_TX_PARITY_EN
            state_r    <= ST_PARITY;
            tx_r       <= par_r;
`else
            state_r    <= ST_STOP;
            tx_r       <= 1'b1;
`endif
          end else begin
            baud_cnt_r <= '0;
            bit_cnt_r  <= bit_cnt_r + 4'd1;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
          end
        end
        ST_PARITY: begin
          if (bit_end_s) begin
            state_r    <= ST_STOP;
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (!bit_end_s) begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
          end else if (frame_end_s) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= '0;
            stop_cnt_r <= stop_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table of single frames plus
// sequences for back-to-back frames, FIFO full, async reset and divisor changes.
module tb_uart_tx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 1 + DATA_BITS + 1 + STOP_BITS;
`else
  localparam int NBITS = 1 + DATA_BITS + STOP_BITS;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DIV_W-1:0]     baud_div = 16'd4;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data = 8'h00;
`ifdef UART_TX_PARITY_EN
  logic                 parity_odd = 1'b0;
`endif
  logic                 tx;
  logic                 busy;
  logic [2:0]           fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          eff_div;
  } vec_t;

  vec_t vecs[6];

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected line sequence, LSB = start bit
  function automatic logic [15:0] exp_frame(input logic [DATA_BITS-1:0] d);
    logic [15:0] f;
    f = 16'h0000;
    for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    f[1+DATA_BITS] = (^d) ^ parity_odd;
    for (int s = 0; s < STOP_BITS; s++) f[2+DATA_BITS+s] = 1'b1;
`else
    for (int s = 0; s < STOP_BITS; s++) f[1+DATA_BITS+s] = 1'b1;
`endif
    return f;
  endfunction

  // Called at the negedge where the start bit is first visible; returns at the
  // negedge after the edge that ends the last stop bit.
  task automatic check_frame(input logic [15:0] f, input int div, input string name);
    int bad_bit;
    bad_bit = -1;
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < div; c++) begin
        if (tx !== f[i] && bad_bit < 0) bad_bit = i;
        @(negedge clk);
      end
    end
    check({name, " frame first bad bit"}, bad_bit, -1);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, " start seen"}, {31'd0, tx}, 32'd0);
  endtask

  task automatic push_word(input logic [7:0] d, input string name);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, " accepted"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, div: 16'd4, eff_div: 4};
    vecs[1] = '{data: 8'h00, div: 16'd2, eff_div: 2};
    vecs[2] = '{data: 8'hFF, div: 16'd3, eff_div: 3};
    vecs[3] = '{data: 8'h3C, div: 16'd0, eff_div: 2};
    vecs[4] = '{data: 8'h81, div: 16'd1, eff_div: 2};
    vecs[5] = '{data: 8'h5A, div: 16'd5, eff_div: 5};

    repeat (3) @(negedge clk);
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset level", {29'd0, fifo_level}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start-bit latency: push on edge k, tx low from edge k+1
    baud_div = 16'd4;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("latency tx still idle", {31'd0, tx}, 32'd1);
    check("latency level", {29'd0, fifo_level}, 32'd1);
    check("latency busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("latency tx start", {31'd0, tx}, 32'd0);
    check("latency level popped", {29'd0, fifo_level}, 32'd0);
    check_frame({6'd0, 1'b1, 8'hA5, 1'b0}, 4, "a5 hand");
    check("a5 busy falls", {31'd0, busy}, 32'd0);
    check("a5 tx idle", {31'd0, tx}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      baud_div = vecs[v].div;
      push_word(vecs[v].data, "vec");
      wait_start("vec");
      check_frame(exp_frame(vecs[v].data), vecs[v].eff_div, "vec");
      check("vec busy falls", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
    end

    // Back-to-back frames at 3 clk/bit
    baud_div = 16'd3;
    fork
      begin
        push_word(8'h55, "b2b");
        check("b2b level 1", {29'd0, fifo_level}, 32'd1);
        push_word(8'h0F, "b2b");
        check("b2b level after push+pop", {29'd0, fifo_level}, 32'd1);
        push_word(8'hF0, "b2b");
        check("b2b level 2", {29'd0, fifo_level}, 32'd2);
      end
      begin
        wait_start("b2b");
        check_frame(exp_frame(8'h55), 3, "b2b 55");
        check_frame(exp_frame(8'h0F), 3, "b2b 0f");
        check_frame(exp_frame(8'hF0), 3, "b2b f0");
        check("b2b busy falls", {31'd0, busy}, 32'd0);
        check("b2b level 0", {29'd0, fifo_level}, 32'd0);
      end
    join
    repeat (2) @(negedge clk);

    // FIFO full: one word in flight plus four queued, sixth held off
    baud_div = 16'd2;
    fork
      begin
        push_word(8'h11, "full");
        push_word(8'h22, "full");
        push_word(8'h33, "full");
        push_word(8'h44, "full");
        push_word(8'h55, "full");
        check("full level 4", {29'd0, fifo_level}, 32'd4);
        check("full in_ready low", {31'd0, in_ready}, 32'd0);
        push_word(8'h66, "full");
      end
      begin
        wait_start("full");
        check_frame(exp_frame(8'h11), 2, "full 11");
        check_frame(exp_frame(8'h22), 2, "full 22");
        check_frame(exp_frame(8'h33), 2, "full 33");
        check_frame(exp_frame(8'h44), 2, "full 44");
        check_frame(exp_frame(8'h55), 2, "full 55");
        check_frame(exp_frame(8'h66), 2, "full 66");
        check("full busy falls", {31'd0, busy}, 32'd0);
        check("full tx idle", {31'd0, tx}, 32'd1);
      end
    join
    repeat (2) @(negedge clk);

    // Async reset in the middle of a data bit driving 0
    baud_div = 16'd4;
    push_word(8'hA5, "rst");
    push_word(8'h11, "rst");
    push_word(8'h22, "rst");
    repeat (8) @(negedge clk);
    check("rst pre tx low", {31'd0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst tx", {31'd0, tx}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst level", {29'd0, fifo_level}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(8'h3C, "post rst");
    wait_start("post rst");
    check_frame(exp_frame(8'h3C), 4, "post rst");
    check("post rst busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // Divisor change mid-frame takes effect on the next frame only
    baud_div = 16'd4;
    fork
      begin
        push_word(8'h96, "div");
        push_word(8'h69, "div");
        repeat (10) @(negedge clk);
        baud_div = 16'd8;
      end
      begin
        wait_start("div");
        check_frame(exp_frame(8'h96), 4, "div old");
        check_frame(exp_frame(8'h69), 8, "div new");
        check("div busy falls", {31'd0, busy}, 32'd0);
      end
    join
    repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    baud_div   = 16'd3;
    parity_odd = 1'b0;
    push_word(8'h07, "par even");
    wait_start("par even");
    check_frame({5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 3, "par even");
    repeat (2) @(negedge clk);
    parity_odd = 1'b1;
    push_word(8'h07, "par odd");
    wait_start("par odd");
    check_frame({5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 3, "par odd");
    repeat (2) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
